vx_commit_gather: RTL and testbench

//  Consumer of the commit interface (slave side). Reassembles partial commit packets
//  (NUM_LANES wide, indexed by pid, framed by sop/eop) into one full NUM_THREADS-wide

---
 rtl/vx_commit_gather_pkg.sv | 40 ++++
 rtl/vx_commit_gather_if.sv | 12 +
 rtl/vx_commit_gather_popcount.sv | 17 +
 rtl/vx_commit_gather.sv | 181 ++++++++++++++++++
 tb/tb_vx_commit_gather.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_commit_gather_pkg.sv
// Shared widths, gather FSM states and the commit packet layout for vx_commit_gather.
package vx_commit_gather_pkg;

   localparam int NUM_THREADS = 16;
   localparam int NUM_LANES   = 4;
   localparam int NUM_PKTS    = NUM_THREADS / NUM_LANES;
   localparam int PID_WIDTH   = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
   localparam int XLEN        = 32;
   localparam int UUID_WIDTH  = 16;
   localparam int NW_WIDTH    = 2;
   localparam int NR_BITS     = 5;
   localparam int CU_WIDTH    = 1;
   localparam int CNT_WIDTH   = $clog2(NUM_THREADS + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATHER = 2'd1,
      ST_FULL   = 2'd2
   } gather_state_e;

   typedef struct packed {
      logic [UUID_WIDTH-1:0]     uuid;
      logic [NW_WIDTH-1:0]       wid;
      logic [NUM_LANES-1:0]      tmask;
      logic [XLEN-1:0]           PC;
      logic                      wb;
      logic [NR_BITS-1:0]        rd;
      logic [NUM_LANES*XLEN-1:0] data;
      logic [PID_WIDTH-1:0]      pid;
      logic                      sop;
      logic                      eop;
      logic [CU_WIDTH-1:0]       cu_id;
   } commit_data_t;

   // A packet index is legal only if it addresses a slice inside the full warp.
   function automatic logic pid_in_range(input logic [PID_WIDTH-1:0] pid);
      return ({1'b0, pid} < (PID_WIDTH + 1)'(NUM_PKTS));
   endfunction

endpackage

// File: rtl/vx_commit_gather_if.sv
// Commit handshake bus: producer drives valid/data, consumer drives ready.
interface vx_commit_gather_if;
   import vx_commit_gather_pkg::*;

   logic         valid;
   commit_data_t data;
   logic         ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_commit_gather_popcount.sv
// Combinational population count of a bit vector.
module vx_commit_gather_popcount #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]             in_bits,
   output logic [$clog2(WIDTH+1)-1:0]   cnt
);

   // Sum the set bits of the input vector.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + ($clog2(WIDTH+1))'(in_bits[i]);
      end
   end

endmodule

// File: rtl/vx_commit_gather.sv
// Reassembles NUM_LANES-wide commit packets into one full-warp writeback and
// emits one retire pulse per instruction; framing violations pulse proto_err.
module vx_commit_gather
   import vx_commit_gather_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   vx_commit_gather_if.slave           commit_if,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [UUID_WIDTH-1:0]       wb_uuid,
   output logic [NW_WIDTH-1:0]         wb_wid,
   output logic [XLEN-1:0]             wb_PC,
   output logic [NR_BITS-1:0]          wb_rd,
   output logic [NUM_THREADS-1:0]      wb_tmask,
   output logic [NUM_THREADS*XLEN-1:0] wb_data,
   output logic                        retire_valid,
   output logic [NW_WIDTH-1:0]         retire_wid,
   output logic [CNT_WIDTH-1:0]        retire_cnt,
   output logic                        proto_err
);

   gather_state_e               state_r, state_nxt_s, base_state_s;
   logic [UUID_WIDTH-1:0]       uuid_r;
   logic [NW_WIDTH-1:0]         wid_r;
   logic [XLEN-1:0]             pc_r;
   logic [NR_BITS-1:0]          rd_r;
   logic                        wb_r;
   logic [NUM_THREADS-1:0]      tmask_r, tmask_nxt_s;
   logic [NUM_THREADS*XLEN-1:0] data_r, data_nxt_s;
   logic [CNT_WIDTH-1:0]        held_cnt_r, cnt_nxt_s;
   logic                        pend_valid_r;
   logic [NW_WIDTH-1:0]         pend_wid_r;
   logic [CNT_WIDTH-1:0]        pend_cnt_r;
   logic                        retire_valid_r;
   logic [NW_WIDTH-1:0]         retire_wid_r;
   logic [CNT_WIDTH-1:0]        retire_cnt_r;
   logic                        proto_err_r;

   commit_data_t                pkt_s;
   logic                        fire_s, drain_s, accept_s, err_s, done_wb0_s, finish_wb_s;
   int                          lane_base_s;
   logic                        unused_cu_s;

   assign pkt_s            = commit_if.data;
   assign unused_cu_s      = ^pkt_s.cu_id;
   // A held writeback leaving this cycle frees the slot, so a new packet may enter.
   assign commit_if.ready  = (state_r != ST_FULL) || wb_ready;
   assign fire_s           = commit_if.valid && commit_if.ready;
   assign drain_s          = (state_r == ST_FULL) && wb_ready;
   assign lane_base_s      = int'(pkt_s.pid) * NUM_LANES;

   assign wb_valid     = (state_r == ST_FULL);
   assign wb_uuid      = uuid_r;
   assign wb_wid       = wid_r;
   assign wb_PC        = pc_r;
   assign wb_rd        = rd_r;
   assign wb_tmask     = tmask_r;
   assign wb_data      = data_r;
   assign retire_valid = retire_valid_r;
   assign retire_wid   = retire_wid_r;
   assign retire_cnt   = retire_cnt_r;
   assign proto_err    = proto_err_r;

   // Merge the incoming lane slice into the buffers; a sop starts from a cleared warp.
   always_comb begin
      tmask_nxt_s = pkt_s.sop ? '0 : tmask_r;
      data_nxt_s  = pkt_s.sop ? '0 : data_r;
      tmask_nxt_s[lane_base_s +: NUM_LANES]              = pkt_s.tmask;
      data_nxt_s[lane_base_s*XLEN +: NUM_LANES*XLEN]     = pkt_s.data;
   end

   vx_commit_gather_popcount #(.WIDTH(NUM_THREADS)) u_popcount (
      .in_bits (tmask_nxt_s),
      .cnt     (cnt_nxt_s)
   );

   // Classify the accepted packet and choose the next gather state.
   always_comb begin
      base_state_s = drain_s ? ST_IDLE : state_r;
      state_nxt_s  = base_state_s;
      accept_s     = 1'b0;
      err_s        = 1'b0;
      done_wb0_s   = 1'b0;
      finish_wb_s  = pkt_s.sop ? pkt_s.wb : wb_r;
      if (fire_s) begin
         if (!pid_in_range(pkt_s.pid)) begin
            err_s = 1'b1;
         end else if (base_state_s == ST_GATHER) begin
            if (pkt_s.sop) begin
               // Restart: the open instruction is abandoned, the new one is taken.
               err_s    = 1'b1;
               accept_s = 1'b1;
            end else if (pkt_s.wid != wid_r) begin
               err_s = 1'b1;
            end else begin
               accept_s = 1'b1;
            end
         end else begin
            if (pkt_s.sop) begin
               accept_s = 1'b1;
            end else begin
               err_s = 1'b1;
            end
         end
      end else begin
         accept_s = 1'b0;
      end
      if (accept_s) begin
         if (!pkt_s.eop) begin
            state_nxt_s = ST_GATHER;
         end else if (finish_wb_s) begin
            state_nxt_s = ST_FULL;
         end else begin
            state_nxt_s = ST_IDLE;
            done_wb0_s  = 1'b1;
         end
      end else begin
         done_wb0_s = 1'b0;
      end
   end

   // Gather FSM, instruction buffers, retire sequencing and error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         uuid_r         <= '0;
         wid_r          <= '0;
         pc_r           <= '0;
         rd_r           <= '0;
         wb_r           <= 1'b0;
         tmask_r        <= '0;
         data_r         <= '0;
         held_cnt_r     <= '0;
         pend_valid_r   <= 1'b0;
         pend_wid_r     <= '0;
         pend_cnt_r     <= '0;
         retire_valid_r <= 1'b0;
         retire_wid_r   <= '0;
         retire_cnt_r   <= '0;
         proto_err_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         proto_err_r <= err_s;
         if (accept_s) begin
            tmask_r    <= tmask_nxt_s;
            data_r     <= data_nxt_s;
            held_cnt_r <= cnt_nxt_s;
            if (pkt_s.sop) begin
               uuid_r <= pkt_s.uuid;
               wid_r  <= pkt_s.wid;
               pc_r   <= pkt_s.PC;
               rd_r   <= pkt_s.rd;
               wb_r   <= pkt_s.wb;
            end else begin
               wb_r <= wb_r;
            end
         end else begin
            tmask_r <= tmask_r;
         end
         // A drain and a no-writeback completion can coincide; the latter waits one cycle.
         if (drain_s || pend_valid_r) begin
            retire_valid_r <= 1'b1;
            retire_wid_r   <= drain_s ? wid_r : pend_wid_r;
            retire_cnt_r   <= drain_s ? held_cnt_r : pend_cnt_r;
            pend_valid_r   <= done_wb0_s;
            pend_wid_r     <= pkt_s.wid;
            pend_cnt_r     <= cnt_nxt_s;
         end else if (done_wb0_s) begin
            retire_valid_r <= 1'b1;
            retire_wid_r   <= pkt_s.wid;
            retire_cnt_r   <= cnt_nxt_s;
            pend_valid_r   <= 1'b0;
         end else begin
            retire_valid_r <= 1'b0;
            pend_valid_r   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vx_commit_gather.sv
// Scoreboard bench for vx_commit_gather: directed packets push expected
// writebacks/retires/errors; a negedge monitor pops and compares them.
module tb_vx_commit_gather;
   import vx_commit_gather_pkg::*;

   localparam int DW = NUM_THREADS * XLEN;

   typedef struct packed {
      logic [UUID_WIDTH+NW_WIDTH+XLEN+NR_BITS-1:0] hdr;
      logic [NUM_THREADS-1:0]                      tmask;
      logic [DW-1:0]                               data;
   } exp_wb_t;

   typedef struct packed {
      logic [NW_WIDTH-1:0]  wid;
      logic [CNT_WIDTH-1:0] cnt;
   } exp_ret_t;

   logic clk = 1'b0;
   logic reset;
   logic wb_valid, wb_ready;
   logic [UUID_WIDTH-1:0] wb_uuid;
   logic [NW_WIDTH-1:0] wb_wid;
   logic [XLEN-1:0] wb_PC;
   logic [NR_BITS-1:0] wb_rd;
   logic [NUM_THREADS-1:0] wb_tmask;
   logic [DW-1:0] wb_data;
   logic retire_valid;
   logic [NW_WIDTH-1:0] retire_wid;
   logic [CNT_WIDTH-1:0] retire_cnt;
   logic proto_err;

   exp_wb_t  wb_q[$];
   exp_ret_t ret_q[$];
   int       err_q[$];
   int       n_checks = 0;
   int       n_errors = 0;

   vx_commit_gather_if cif ();

   vx_commit_gather dut (
      .clk(clk), .reset(reset), .commit_if(cif),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
      .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data),
      .retire_valid(retire_valid), .retire_wid(retire_wid), .retire_cnt(retire_cnt),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Packet whose lane i of slice pid carries base + pid*NUM_LANES + i.
   function automatic commit_data_t mk(input logic [15:0] uuid, input logic [1:0] wid,
                                       input logic wb, input logic [PID_WIDTH-1:0] pid,
                                       input logic sop, input logic eop,
                                       input logic [NUM_LANES-1:0] tm, input logic [31:0] base);
      commit_data_t p;
      p = '0;
      p.uuid = uuid; p.wid = wid; p.PC = {16'h8000, uuid}; p.rd = uuid[4:0];
      p.wb = wb; p.pid = pid; p.sop = sop; p.eop = eop; p.tmask = tm;
      for (int i = 0; i < NUM_LANES; i++)
         p.data[i*XLEN +: XLEN] = base + 32'(int'(pid) * NUM_LANES + i);
      return p;
   endfunction

   // Expected warp data: global lane g = base + g for the first n lanes, zero above.
   function automatic logic [DW-1:0] exp_data(input logic [31:0] base, input int n);
      logic [DW-1:0] d;
      d = '0;
      for (int g = 0; g < n; g++) d[g*XLEN +: XLEN] = base + 32'(g);
      return d;
   endfunction

   task automatic push_wb(input logic [15:0] uuid, input logic [1:0] wid,
                          input logic [15:0] tm, input logic [DW-1:0] d);
      exp_wb_t e;
      e.hdr = {uuid, wid, {16'h8000, uuid}, uuid[4:0]};
      e.tmask = tm;
      e.data = d;
      wb_q.push_back(e);
   endtask

   task automatic push_ret(input logic [1:0] wid, input logic [CNT_WIDTH-1:0] cnt);
      exp_ret_t r;
      r.wid = wid;
      r.cnt = cnt;
      ret_q.push_back(r);
   endtask

   task automatic send(input commit_data_t p);
      int n;
      n = 0;
      cif.valid = 1'b1;
      cif.data = p;
      @(negedge clk);
      while (!cif.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cif.ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: got ready=0 expected ready=1");
      end
      @(posedge clk);
      #1;
      cif.valid = 1'b0;
   endtask

   // Monitor: compare every DUT output event against the head of its queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (wb_valid && wb_ready) begin
            if (wb_q.size() == 0) unexpected("wb_unexpected");
            else begin
               exp_wb_t e;
               e = wb_q.pop_front();
               chk("wb_hdr", DW'({wb_uuid, wb_wid, wb_PC, wb_rd}), DW'(e.hdr));
               chk("wb_tmask", DW'(wb_tmask), DW'(e.tmask));
               chk("wb_data", wb_data, e.data);
            end
         end
         if (retire_valid) begin
            if (ret_q.size() == 0) unexpected("retire_unexpected");
            else begin
               exp_ret_t r;
               r = ret_q.pop_front();
               chk("retire", DW'({retire_wid, retire_cnt}), DW'({r.wid, r.cnt}));
            end
         end
         if (proto_err) begin
            if (err_q.size() == 0) unexpected("proto_err_unexpected");
            else begin
               int tag;
               tag = err_q.pop_front();
               chk("proto_err_seen", DW'(proto_err), DW'(1'b1));
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      wb_ready = 1'b1;
      cif.valid = 1'b0;
      cif.data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_outs", DW'({wb_valid, wb_tmask, retire_valid, proto_err, wb_wid, retire_cnt}), '0);
      chk("reset_data", wb_data, '0);
      chk("reset_ready", DW'(cif.ready), DW'(1'b1));
      @(posedge clk); #1;

      // Four-slice instruction, full mask, wid 2.
      push_wb(16'd1, 2'd2, 16'hFFFF, exp_data(32'h1000_0000, 16));
      push_ret(2'd2, 5'd16);
      send(mk(16'd1, 2'd2, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h1000_0000));
      send(mk(16'd1, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0, 4'hF, 32'h1000_0000));
      send(mk(16'd1, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 4'hF, 32'h1000_0000));
      send(mk(16'd1, 2'd2, 1'b1, 2'd3, 1'b0, 1'b1, 4'hF, 32'h1000_0000));
      @(negedge clk);
      chk("wb_latency", DW'(wb_valid), DW'(1'b1));
      @(posedge clk); #1;

      // Single sop&eop without writeback: retire only.
      push_ret(2'd1, 5'd2);
      send(mk(16'd2, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0011, 32'h2000_0000));
      @(negedge clk);
      chk("retire_latency", DW'({retire_valid, wb_valid}), DW'(2'b10));
      @(posedge clk); #1;

      // Back-pressure in FULL, then drain while the next sop is accepted.
      wb_ready = 1'b0;
      push_wb(16'd3, 2'd3, 16'hAAAA, exp_data(32'h3000_0000, 16));
      push_ret(2'd3, 5'd8);
      for (int p = 0; p < 4; p++)
         send(mk(16'd3, 2'd3, 1'b1, 2'(p), p == 0, p == 3, 4'b1010, 32'h3000_0000));
      cif.valid = 1'b1;
      cif.data = mk(16'd4, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h4000_0000);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_ready", DW'({cif.ready, wb_valid}), DW'(2'b01));
         chk("stall_data", wb_data, exp_data(32'h3000_0000, 16));
         chk("stall_tmask", DW'(wb_tmask), DW'(16'hAAAA));
         @(posedge clk); #1;
      end
      wb_ready = 1'b1;
      @(negedge clk);
      chk("drain_both_fire", DW'({cif.ready, wb_valid}), DW'(2'b11));
      @(posedge clk); #1;
      cif.valid = 1'b0;
      push_wb(16'd4, 2'd0, 16'hFFFF, exp_data(32'h4000_0000, 16));
      push_ret(2'd0, 5'd16);
      for (int p = 1; p < 4; p++)
         send(mk(16'd4, 2'd0, 1'b1, 2'(p), 1'b0, p == 3, 4'hF, 32'h4000_0000));

      // Non-sop packet while idle.
      err_q.push_back(1);
      send(mk(16'd9, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 4'hF, 32'hBAD0_0000));

      // Wid change mid-gather is dropped; the instruction still completes.
      push_wb(16'd5, 2'd0, 16'hFFFF, exp_data(32'h5000_0000, 16));
      push_ret(2'd0, 5'd16);
      send(mk(16'd5, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h5000_0000));
      err_q.push_back(2);
      send(mk(16'd5, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 4'hF, 32'hDEAD_0000));
      for (int p = 1; p < 4; p++)
         send(mk(16'd5, 2'd0, 1'b1, 2'(p), 1'b0, p == 3, 4'hF, 32'h5000_0000));

      // sop inside gather abandons the open instruction.
      send(mk(16'd6, 2'd1, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h6000_0000));
      err_q.push_back(3);
      push_wb(16'd7, 2'd2, 16'h00FF, exp_data(32'h7000_0000, 8));
      push_ret(2'd2, 5'd8);
      send(mk(16'd7, 2'd2, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h7000_0000));
      send(mk(16'd7, 2'd2, 1'b1, 2'd1, 1'b0, 1'b1, 4'hF, 32'h7000_0000));

      // Sparse mask only in slice 1.
      push_wb(16'd8, 2'd1, 16'h0050, exp_data(32'h8000_0000, 8));
      push_ret(2'd1, 5'd2);
      send(mk(16'd8, 2'd1, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 32'h8000_0000));
      send(mk(16'd8, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b0101, 32'h8000_0000));
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a gather loses it.
      send(mk(16'd10, 2'd3, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h9000_0000));
      send(mk(16'd10, 2'd3, 1'b1, 2'd1, 1'b0, 1'b0, 4'hF, 32'h9000_0000));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_outs", DW'({wb_valid, wb_tmask, retire_valid, proto_err, wb_wid}), '0);
      chk("midreset_data", wb_data, '0);
      @(posedge clk); #1;
      push_wb(16'd11, 2'd0, 16'h00FF, exp_data(32'hA000_0000, 8));
      push_ret(2'd0, 5'd8);
      send(mk(16'd11, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 4'hF, 32'hA000_0000));
      send(mk(16'd11, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 4'hF, 32'hA000_0000));

      repeat (10) @(posedge clk);
      chk("wb_q_empty", DW'(wb_q.size()), '0);
      chk("ret_q_empty", DW'(ret_q.size()), '0);
      chk("err_q_empty", DW'(err_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
